// File: rtl/bk_multiword_add_ctrl.sv
// rtl/bk_multiword_add_ctrl.sv - wide add/sub sequencer over one shared Brent-Kung chunk adder
module brent_kung_adder_nbit #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int LG = $clog2(N);

    logic [N-1:0] p;
    logic [N-1:0] gg;
    logic [N-1:0] pp;
    logic [N-1:0] carries;

    always_comb begin
        p  = a ^ b;
        gg = a & b;
        pp = p;
        // Fold cin into bit 0 so every group generate is a full prefix carry.
        gg[0] = gg[0] | (p[0] & cin);
        for (int l = 0; l < LG; l++) begin
            for (int i = (2 << l) - 1; i < N; i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
        for (int l = LG - 2; l >= 0; l--) begin
            for (int i = (2 << l) + (1 << l) - 1; i < N; i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
        carries = {gg[N-2:0], cin};
        sum     = p ^ carries;
        cout    = gg[N-1];
    end
endmodule

module bk_multiword_add_ctrl #(
    parameter int ADDER_SIZE = 32,
    parameter int NUM_CHUNKS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_sub,
    input  logic [ADDER_SIZE*NUM_CHUNKS-1:0] req_op1,
    input  logic [ADDER_SIZE*NUM_CHUNKS-1:0] req_op2,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ADDER_SIZE*NUM_CHUNKS-1:0] rsp_res,
    output logic                             rsp_cout,
    output logic                             rsp_ovf,
    output logic                             rsp_zero
);
    localparam int W  = ADDER_SIZE * NUM_CHUNKS;
    localparam int CW = $clog2(NUM_CHUNKS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                state;
    logic [W-1:0]          op1_q;
    logic [W-1:0]          op2_q;
    logic                  carry;
    logic [CW-1:0]         idx;

    logic [ADDER_SIZE-1:0] a_chunk;
    logic [ADDER_SIZE-1:0] b_chunk;
    logic [ADDER_SIZE-1:0] sum;
    logic                  cout;
    logic [W-1:0]          res_next;
    logic                  cin_msb;

    // Adder inputs come straight from registers: one adder delay per cycle.
    always_comb begin
        a_chunk  = op1_q[int'(idx) * ADDER_SIZE +: ADDER_SIZE];
        b_chunk  = op2_q[int'(idx) * ADDER_SIZE +: ADDER_SIZE];
        res_next = rsp_res;
        res_next[int'(idx) * ADDER_SIZE +: ADDER_SIZE] = sum;
        cin_msb  = sum[ADDER_SIZE-1] ^ a_chunk[ADDER_SIZE-1] ^ b_chunk[ADDER_SIZE-1];
    end

    brent_kung_adder_nbit #(
        .N(ADDER_SIZE)
    ) u_adder (
        .a   (a_chunk),
        .b   (b_chunk),
        .cin (carry),
        .sum (sum),
        .cout(cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op1_q     <= '0;
            op2_q     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        op1_q     <= req_op1;
                        // Subtraction is op1 + ~op2 + 1; the +1 enters as the initial carry.
                        op2_q     <= req_sub ? ~req_op2 : req_op2;
                        carry     <= req_sub;
                        idx       <= '0;
                        req_ready <= 1'b0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    rsp_res <= res_next;
                    carry   <= cout;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        rsp_cout  <= cout;
                        rsp_ovf   <= cin_msb ^ cout;
                        rsp_zero  <= (res_next == '0);
                        rsp_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bk_multiword_add_ctrl.sv
// tb/tb_bk_multiword_add_ctrl.sv - randomized and directed bench for bk_multiword_add_ctrl
module tb_bk_multiword_add_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_sub;
    logic [63:0] op1;
    logic [63:0] op2;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic        a_rsp_cout, a_rsp_ovf, a_rsp_zero;
    logic [31:0] a_rsp_res;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic        b_rsp_cout, b_rsp_ovf, b_rsp_zero;
    logic [63:0] b_rsp_res;

    int total = 0;
    int bad   = 0;

    bk_multiword_add_ctrl #(.ADDER_SIZE(8), .NUM_CHUNKS(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_sub(req_sub),
        .req_op1(op1[31:0]), .req_op2(op2[31:0]),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_res(a_rsp_res),
        .rsp_cout(a_rsp_cout), .rsp_ovf(a_rsp_ovf), .rsp_zero(a_rsp_zero)
    );

    bk_multiword_add_ctrl #(.ADDER_SIZE(32), .NUM_CHUNKS(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_sub(req_sub),
        .req_op1(op1), .req_op2(op2),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_res(b_rsp_res),
        .rsp_cout(b_rsp_cout), .rsp_ovf(b_rsp_ovf), .rsp_zero(b_rsp_zero)
    );

    // Golden W-bit arithmetic, returned as {cout, ovf, zero, res[63:0]}.
    function automatic logic [66:0] model(input int w, input logic sub,
                                          input logic [63:0] x, input logic [63:0] y);
        logic [64:0] mask, xv, yv, s, res;
        logic cout, ovf, s1, s2, sr;
        mask = (w == 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << w) - 65'd1);
        xv = {1'b0, x} & mask;
        yv = {1'b0, y} & mask;
        if (!sub) begin
            s    = xv + yv;
            cout = s[w];
            res  = s & mask;
        end else begin
            cout = (xv >= yv);
            res  = (xv - yv) & mask;
        end
        s1  = xv[w-1];
        s2  = yv[w-1];
        sr  = res[w-1];
        ovf = sub ? ((s1 != s2) && (sr != s1)) : ((s1 == s2) && (sr != s1));
        return {cout, ovf, (res == 65'd0), res[63:0]};
    endfunction

    task automatic run_a(input logic sub, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic [34:0] got);
        int n;
        @(negedge clk);
        req_sub = sub; op1 = {32'd0, x}; op2 = {32'd0, y};
        a_req_valid = 1'b1; a_rsp_ready = 1'b0;
        n = 0;
        while (!a_req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        a_req_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        got = {a_rsp_cout, a_rsp_ovf, a_rsp_zero, a_rsp_res};
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_sub = 1'b0; op1 = '0; op2 = '0;
        a_req_valid = 1'b0; a_rsp_ready = 1'b0; b_req_valid = 1'b0; b_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({a_rsp_valid, a_rsp_cout, a_rsp_ovf, a_rsp_zero, a_rsp_res} !== 36'd0) begin
            bad++; $display("FAIL reset_a_outputs got=%h want=0",
                            {a_rsp_valid, a_rsp_cout, a_rsp_ovf, a_rsp_zero, a_rsp_res});
        end
        total++;
        if ({b_rsp_valid, b_rsp_cout, b_rsp_ovf, b_rsp_zero, b_rsp_res} !== 68'd0) begin
            bad++; $display("FAIL reset_b_outputs got=%h want=0",
                            {b_rsp_valid, b_rsp_cout, b_rsp_ovf, b_rsp_zero, b_rsp_res});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid} !== 4'b1010) begin
            bad++; $display("FAIL reset_release_ready got=%b want=1010",
                            {a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid});
        end
    endtask

    task automatic test_directed();
        logic        subs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] xs[7]   = '{32'hFFFF_FFFF, 32'h5, 32'h7, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h5};
        logic [31:0] ys[7]   = '{32'h1, 32'h7, 32'h5, 32'h1, 32'h1, 32'h0, 32'h5};
        logic [2:0]  fl[7]   = '{3'b101, 3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101};
        logic [31:0] rs[7]   = '{32'h0, 32'hFFFF_FFFE, 32'h2, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0};
        int lat;
        logic [34:0] got;
        for (int i = 0; i < 7; i++) begin
            run_a(subs[i], xs[i], ys[i], lat, got);
            total++;
            if (got !== {fl[i], rs[i]}) begin
                bad++; $display("FAIL directed_%0d got=%h want=%h", i, got, {fl[i], rs[i]});
            end
            total++;
            if (lat != 5) begin
                bad++; $display("FAIL latency_%0d got=%0d want=5", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] snap;
        int n;
        @(negedge clk);
        req_sub = 1'b0; op1 = 64'h1234_5678; op2 = 64'h1111_1111;
        a_req_valid = 1'b1; a_rsp_ready = 1'b0;
        n = 0;
        while (!a_req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_sub = 1'b1; op1 = 64'h10; op2 = 64'h20;
        n = 0;
        while (!a_rsp_valid && n < 50) begin @(negedge clk); n++; end
        snap = {a_rsp_valid, a_rsp_cout, a_rsp_ovf, a_rsp_zero, a_rsp_res};
        total++;
        if (snap !== {1'b1, 3'b000, 32'h2345_6789}) begin
            bad++; $display("FAIL bp_first_result got=%h want=%h", snap, {1'b1, 3'b000, 32'h2345_6789});
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({a_req_ready, a_rsp_valid, a_rsp_cout, a_rsp_ovf, a_rsp_zero, a_rsp_res} !== {1'b0, snap}) begin
                bad++; $display("FAIL bp_hold_%0d got=%h want=%h", c,
                    {a_req_ready, a_rsp_valid, a_rsp_cout, a_rsp_ovf, a_rsp_zero, a_rsp_res}, {1'b0, snap});
            end
        end
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
        total++;
        if ({a_rsp_valid, a_req_ready} !== 2'b01) begin
            bad++; $display("FAIL bp_release got=%b want=01", {a_rsp_valid, a_req_ready});
        end
        @(negedge clk);
        a_req_valid = 1'b0;
        n = 1;
        while (!a_rsp_valid && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n != 5 || {a_rsp_cout, a_rsp_ovf, a_rsp_zero, a_rsp_res} !== {3'b000, 32'hFFFF_FFF0}) begin
            bad++; $display("FAIL bp_second got=%h lat=%0d want=%h lat=5",
                            {a_rsp_cout, a_rsp_ovf, a_rsp_zero, a_rsp_res}, n, {3'b000, 32'hFFFF_FFF0});
        end
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int n, lat;
        logic [34:0] got;
        @(negedge clk);
        req_sub = 1'b0; op1 = 64'h0102_0304; op2 = 64'h1020_3040;
        a_req_valid = 1'b1; a_rsp_ready = 1'b1;
        n = 0;
        while (!a_req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        a_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({a_rsp_valid, a_rsp_cout, a_rsp_ovf, a_rsp_zero, a_rsp_res} !== 36'd0) begin
            bad++; $display("FAIL midrun_reset_outputs got=%h want=0",
                            {a_rsp_valid, a_rsp_cout, a_rsp_ovf, a_rsp_zero, a_rsp_res});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if ({a_req_ready, a_rsp_valid} !== 2'b10) begin
                bad++; $display("FAIL midrun_after_%0d got=%b want=10", c, {a_req_ready, a_rsp_valid});
            end
        end
        a_rsp_ready = 1'b0;
        run_a(1'b1, 32'hDEAD_BEEF, 32'h0000_BEEF, lat, got);
        total++;
        if (got !== {3'b100, 32'hDEAD_0000} || lat != 5) begin
            bad++; $display("FAIL midrun_next_op got=%h lat=%0d want=%h lat=5", got, lat, {3'b100, 32'hDEAD_0000});
        end
    endtask

    task automatic test_random(input bit wide, input int nreq);
        logic [66:0] exp_q[$];
        logic [66:0] e, obs;
        logic [63:0] x, y;
        logic        sb, rr, rv;
        int sent = 0, done = 0, cyc = 0;
        int w = wide ? 64 : 32;
        @(negedge clk);
        while ((sent < nreq || exp_q.size() > 0) && cyc < 40000) begin
            rr  = ($urandom % 4) != 0;
            obs = wide ? {b_rsp_cout, b_rsp_ovf, b_rsp_zero, b_rsp_res}
                       : {a_rsp_cout, a_rsp_ovf, a_rsp_zero, 32'd0, a_rsp_res};
            if ((wide ? b_rsp_valid : a_rsp_valid) && rr) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_w%0d_unexpected_rsp got=%h want=none", w, obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        bad++; $display("FAIL rand_w%0d_rsp_%0d got=%h want=%h", w, done, obs, e);
                    end
                    done++;
                end
            end
            rv = (sent < nreq) && (($urandom % 4) != 0);
            sb = $urandom_range(0, 1);
            x  = {$urandom, $urandom};
            y  = {$urandom, $urandom};
            case ($urandom % 8)
                0: x = '1;
                1: x = '0;
                2: x = 64'd1 << (w - 1);
                3: x = (64'd1 << (w - 1)) - 64'd1;
                default: ;
            endcase
            case ($urandom % 8)
                0: y = '1;
                1: y = '0;
                2: y = 64'd1;
                3: y = 64'd1 << (w - 1);
                default: ;
            endcase
            if (rv && (wide ? b_req_ready : a_req_ready)) begin
                exp_q.push_back(model(w, sb, x, y));
                sent++;
            end
            req_sub = sb; op1 = x; op2 = y;
            if (wide) begin b_req_valid = rv; b_rsp_ready = rr; end
            else      begin a_req_valid = rv; a_rsp_ready = rr; end
            @(negedge clk);
            cyc++;
        end
        a_req_valid = 1'b0; a_rsp_ready = 1'b0; b_req_valid = 1'b0; b_rsp_ready = 1'b0;
        total++;
        if (done != nreq) begin
            bad++; $display("FAIL rand_w%0d_count got=%0d want=%0d", w, done, nreq);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midrun();
        test_random(1'b0, 2000);
        test_random(1'b1, 2000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
